// File: rtl/injection_pkg.sv
// Shared types, constants and sticky-latch golden equations for the injection
// block and its stimulus checker.
package injection_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned STIM_W = 6;

    // Fibonacci taps 16,14,13,11 for a left-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [ERR_W-1:0]  ERR_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } stim_t;

    function automatic logic y1_next(input logic y1, input logic a, input logic b,
                                     input logic c);
        return (y1 | a | b) & c;
    endfunction

    function automatic logic y2_next(input logic y2, input logic d, input logic e,
                                     input logic f);
        return (y2 | ~d) & (e | ~f);
    endfunction

endpackage

// File: rtl/injection_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and shift enable.
module injection_lfsr16
    import injection_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_VAL;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/injection_stim_checker.sv
// Drives LFSR stimulus into the injection block and checks its y1/y2 responses
// against the sticky-latch golden model, reporting errors per run.
module injection_stim_checker
    import injection_pkg::*;
#(
    parameter int unsigned       NUM_VECTORS    = 256,
    parameter int unsigned       IDX_W          = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned       DUT_RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             dut_rstn,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    input  logic             y1_in,
    input  logic             y2_in,
    output logic             mismatch,
    output logic [1:0]       mismatch_bits,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic             first_err_vld
);

    localparam int unsigned     RC_W     = (DUT_RST_CYCLES > 1) ? $clog2(DUT_RST_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(DUT_RST_CYCLES - 1);

    state_t            state;
    stim_t             stim;
    logic [IDX_W-1:0]  idx;
    logic [RC_W-1:0]   rst_cnt;
    logic              exp_y1;
    logic              exp_y2;
    logic [LFSR_W-1:0] lfsr;

    logic              lfsr_load_c;
    logic              lfsr_en_c;
    logic              cmp_c;
    logic [1:0]        fail_c;
    logic [IDX_W-1:0]  cause_idx_c;
    logic [ERR_W-1:0]  err_next_c;

    assign {a, b, c, d, e, f} = {stim.a, stim.b, stim.c, stim.d, stim.e, stim.f};
    assign busy = (state != IDLE);

    // Reload on start; an all-zero register (never reachable from a nonzero seed) is also reloaded
    assign lfsr_load_c = ((state == IDLE) && start && !abort) || (lfsr == '0);
    assign lfsr_en_c   = !abort && (((state == DUT_RST) && (rst_cnt == LAST_RC)) ||
                                    ((state == RUN) && (idx != LAST_IDX)));

    assign cmp_c       = ((state == RUN) || (state == DRAIN)) && !abort;
    assign fail_c      = {y2_in ^ exp_y2, y1_in ^ exp_y1};
    assign cause_idx_c = (state == DRAIN) ? LAST_IDX :
                         (idx == '0)      ? '0       : idx - IDX_W'(1);
    assign err_next_c  = (cmp_c && (|fail_c) && (err_count != ERR_MAX)) ?
                         err_count + ERR_W'(1) : err_count;

    injection_lfsr16 #(
        .RST_VAL(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load_c),
        .en   (lfsr_en_c),
        .seed (LFSR_SEED),
        .state(lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            stim          <= '0;
            idx           <= '0;
            rst_cnt       <= '0;
            exp_y1        <= 1'b0;
            exp_y2        <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            dut_rstn      <= 1'b1;
            mismatch      <= 1'b0;
            mismatch_bits <= 2'b00;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            done          <= 1'b0;
            mismatch      <= 1'b0;
            mismatch_bits <= 2'b00;

            if (cmp_c) begin
                mismatch      <= |fail_c;
                mismatch_bits <= fail_c;
                err_count     <= err_next_c;
                if ((|fail_c) && !first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= cause_idx_c;
                end
            end

            if ((state != IDLE) && abort) begin
                state    <= IDLE;
                dut_rstn <= 1'b1;
                stim     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state         <= DUT_RST;
                            rst_cnt       <= '0;
                            err_count     <= '0;
                            first_err_vld <= 1'b0;
                            pass          <= 1'b0;
                            exp_y1        <= 1'b0;
                            exp_y2        <= 1'b0;
                            dut_rstn      <= 1'b0;
                            stim          <= '0;
                        end
                    end
                    DUT_RST: begin
                        if (rst_cnt == LAST_RC) begin
                            state    <= RUN;
                            idx      <= '0;
                            dut_rstn <= 1'b1;
                            stim     <= stim_t'(lfsr[STIM_W-1:0]);
                        end else begin
                            rst_cnt <= rst_cnt + RC_W'(1);
                        end
                    end
                    RUN: begin
                        exp_y1 <= y1_next(exp_y1, stim.a, stim.b, stim.c);
                        exp_y2 <= y2_next(exp_y2, stim.d, stim.e, stim.f);
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                            stim  <= '0;
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            stim <= stim_t'(lfsr[STIM_W-1:0]);
                        end
                    end
                    DRAIN: begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_next_c == '0);
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_injection_stim_checker.sv
// Bench for injection_stim_checker: a behavioural injection block closes the loop,
// table-driven runs inject response faults, a queue predicts mismatch pulses.
module tb_injection_stim_checker;

    localparam int unsigned N    = 8;
    localparam int unsigned IW   = 8;
    localparam int unsigned D    = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pass;
    logic          dut_rstn;
    logic          a, b, c, d, e, f;
    logic          y1_in, y2_in;
    logic          mismatch;
    logic [1:0]    mismatch_bits;
    logic [15:0]   err_count;
    logic [IW-1:0] first_err_idx;
    logic          first_err_vld;

    logic          blk_y1, blk_y2;
    logic          inj1, inj2;
    int            checks = 0;
    int            errors = 0;
    logic [1:0]    sb_q[$];

    typedef struct {
        int         inj_c;
        logic [1:0] inj_b;
        int         abort_c;
        int         restart_cyc;
        logic [15:0] exp_err;
        logic       exp_pass;
        logic       exp_vld;
        logic [7:0] exp_idx;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    injection_stim_checker #(
        .NUM_VECTORS   (N),
        .IDX_W         (IW),
        .LFSR_SEED     (SEED),
        .DUT_RST_CYCLES(D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .dut_rstn     (dut_rstn),
        .a            (a),
        .b            (b),
        .c            (c),
        .d            (d),
        .e            (e),
        .f            (f),
        .y1_in        (y1_in),
        .y2_in        (y2_in),
        .mismatch     (mismatch),
        .mismatch_bits(mismatch_bits),
        .err_count    (err_count),
        .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld)
    );

    // Correct behavioural injection block; faults are XORed onto its responses
    always_ff @(posedge clk or negedge dut_rstn) begin
        if (!dut_rstn) begin
            blk_y1 <= 1'b0;
            blk_y2 <= 1'b0;
        end else begin
            blk_y1 <= (blk_y1 | a | b) & c;
            blk_y2 <= (blk_y2 | ~d) & (e | ~f);
        end
    end

    assign y1_in = blk_y1 ^ inj1;
    assign y2_in = blk_y2 ^ inj2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_dut_rstn"}, dut_rstn, 1);
        chk({tag, "_stim"}, {f, e, d, c, b, a}, 0);
        chk({tag, "_mismatch"}, mismatch, 0);
        chk({tag, "_mismatch_bits"}, mismatch_bits, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_err_idx"}, first_err_idx, 0);
        chk({tag, "_first_err_vld"}, first_err_vld, 0);
    endtask

    // One complete run; start is presented at the current negedge
    task automatic do_run(input vec_t v, input string tag);
        logic [15:0] l;
        logic [5:0]  first3[3];
        logic [5:0]  stim_now;
        logic [1:0]  pend;
        logic [1:0]  ib;
        int          ab_cyc;
        int          last;
        int          seen;
        l = SEED;
        sb_q.delete();
        for (int i = 0; i < 3; i++) first3[i] = 6'h00;
        ab_cyc = (v.abort_c >= 0) ? int'(D) + 1 + v.abort_c : -1;
        last   = (ab_cyc >= 0) ? ab_cyc + 1 : int'(D + N + 3);
        start  = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            inj1  = 1'b0;
            inj2  = 1'b0;
            if (sb_q.size() > 0) begin
                pend = sb_q.pop_front();
                chk({tag, "_mismatch"}, mismatch, |pend);
                chk({tag, "_mismatch_bits"}, mismatch_bits, pend);
            end
            stim_now = {f, e, d, c, b, a};
            if (ab_cyc >= 0 && cyc == ab_cyc + 1) begin
                chk({tag, "_abort_busy"}, busy, 0);
                chk({tag, "_abort_dut_rstn"}, dut_rstn, 1);
                chk({tag, "_abort_stim"}, stim_now, 0);
                chk({tag, "_abort_err_count"}, err_count, v.exp_err);
                chk({tag, "_abort_first_vld"}, first_err_vld, v.exp_vld);
                chk({tag, "_abort_first_idx"}, first_err_idx, v.exp_idx);
                chk({tag, "_abort_pass"}, pass, 0);
            end else if (cyc <= int'(D)) begin
                chk({tag, "_rst_busy"}, busy, 1);
                chk({tag, "_rst_dut_rstn"}, dut_rstn, 0);
                chk({tag, "_rst_stim"}, stim_now, 0);
                if (cyc == 1) begin
                    chk({tag, "_clr_err_count"}, err_count, 0);
                    chk({tag, "_clr_first_vld"}, first_err_vld, 0);
                    chk({tag, "_clr_pass"}, pass, 0);
                end
            end else if (cyc <= int'(D + N)) begin
                chk({tag, "_run_dut_rstn"}, dut_rstn, 1);
                chk({tag, "_run_stim"}, stim_now, l[5:0]);
                chk({tag, "_run_done"}, done, 0);
                if (cyc - int'(D) - 1 < 3) first3[cyc - int'(D) - 1] = stim_now;
                l = lfsr_step(l);
            end else if (cyc == int'(D + N + 1)) begin
                chk({tag, "_drain_stim"}, stim_now, 0);
                chk({tag, "_drain_done"}, done, 0);
                chk({tag, "_drain_busy"}, busy, 1);
            end else if (cyc == int'(D + N + 2)) begin
                chk({tag, "_done_pulse"}, done, 1);
                chk({tag, "_done_pass"}, pass, v.exp_pass);
                chk({tag, "_done_err_count"}, err_count, v.exp_err);
                chk({tag, "_done_first_vld"}, first_err_vld, v.exp_vld);
                if (v.exp_vld) chk({tag, "_done_first_idx"}, first_err_idx, v.exp_idx);
            end else begin
                chk({tag, "_end_done"}, done, 0);
                chk({tag, "_end_busy"}, busy, 0);
                chk({tag, "_end_pass"}, pass, v.exp_pass);
            end
            // Drive the response fault for the compare at the coming edge
            if (cyc == ab_cyc) begin
                abort = 1'b1;
                sb_q.push_back(2'b00);
            end else if (cyc >= int'(D) + 1 && cyc <= int'(D + N) + 1 &&
                         (ab_cyc < 0 || cyc < ab_cyc)) begin
                ib   = ((cyc - int'(D) - 1) == v.inj_c) ? v.inj_b : 2'b00;
                inj1 = ib[0];
                inj2 = ib[1];
                sb_q.push_back(ib);
            end
            if (cyc == v.restart_cyc) start = 1'b1;
        end
        if (ab_cyc >= 0) begin
            seen = 0;
            repeat (D + N + 4) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk({tag, "_no_done_after_abort"}, seen, 0);
            chk({tag, "_idle_after_abort"}, busy, 0);
        end
        if (v.abort_c < 0 || v.abort_c >= 3) begin
            chk({tag, "_vec0"}, first3[0], 6'h21);
            chk({tag, "_vec1"}, first3[1], 6'h03);
            chk({tag, "_vec2"}, first3[2], 6'h07);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{-1, 2'b00, -1, -1,               16'd0, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{ 5, 2'b10, -1, -1,               16'd1, 1'b0, 1'b1, 8'd4};
        tbl[2] = '{ 0, 2'b01, -1, -1,               16'd1, 1'b0, 1'b1, 8'd0};
        tbl[3] = '{ 8, 2'b11, -1, -1,               16'd1, 1'b0, 1'b1, 8'd7};
        tbl[4] = '{ 1, 2'b01,  3, -1,               16'd1, 1'b0, 1'b1, 8'd0};
        tbl[5] = '{-1, 2'b00, -1, int'(D) + 3,      16'd0, 1'b1, 1'b0, 8'd0};
        tbl[6] = '{-1, 2'b00, -1, int'(D + N) + 2,  16'd0, 1'b1, 1'b0, 8'd0};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        inj1  = 1'b0;
        inj2  = 1'b0;
        @(negedge clk);
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        // start and abort together in IDLE: no run
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_wins_busy", busy, 0);
        chk("idle_abort_wins_dut_rstn", dut_rstn, 1);

        for (int i = 0; i < 7; i++) begin
            do_run(tbl[i], $sformatf("run%0d", i));
        end

        // Asynchronous reset in the middle of RUN after one error has been logged
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        inj1 = 1'b1;
        @(negedge clk);
        inj1 = 1'b0;
        chk("midrst_pre_mismatch", mismatch, 1);
        @(negedge clk);
        chk("midrst_pre_err_count", err_count, 1);
        chk("midrst_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_busy", busy, 0);
        chk("midrst_after_dut_rstn", dut_rstn, 1);

        do_run(tbl[0], "recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
